hella_cache_mem_responder: RTL and testbench

- Downstream consumer of the core-side HellaCache dmem port that the Rocket data-memory master drives.
- Models the three-stage dmem timing the master expects: s0 request accept, s1 store data/kill window, s2 response or nack.
- Backed by a local word-addressed 64-bit memory, so the subsystem bench can close the loop without a real L1.

---
 rtl/hella_cache_pkg.sv | 36 +++
 rtl/hella_load_extract.sv | 26 ++
 rtl/hella_cache_mem_responder.sv | 114 +++++++++++
 tb/tb_hella_cache_mem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hella_cache_pkg.sv
// Shared types and constants for the HellaCache dmem responder.
package hella_cache_pkg;

    localparam logic [4:0] M_XRD = 5'd0;
    localparam logic [4:0] M_XWR = 5'd1;

    typedef enum logic [1:0] {
        MT_B = 2'd0,
        MT_H = 2'd1,
        MT_W = 2'd2,
        MT_D = 2'd3
    } mt_size_e;

    // typ[2] selects zero extension of load data
    localparam int unsigned TYP_UNSIGNED_BIT = 2;

    // Pipeline register fields are sized for the widest supported request
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [15:0] tag;
        logic [4:0]  cmd;
        logic [2:0]  typ;
        logic        err;
    } pipe_reg_t;

    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
        case (mt_size_e'(size))
            MT_B:    return 1'b0;
            MT_H:    return off[0];
            MT_W:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/hella_load_extract.sv
// Selects the addressed bytes of a 64-bit word and sign/zero-extends them.
module hella_load_extract
    import hella_cache_pkg::*;
(
    input  logic [63:0] word_i,
    input  logic [2:0]  off_i,
    input  logic [2:0]  typ_i,
    output logic [63:0] data_o
);

    logic [63:0] shifted;
    logic        sgn;

    // Shift the addressed byte to bit 0, then extend to the access size
    always_comb begin
        shifted = word_i >> {off_i, 3'b000};
        sgn     = ~typ_i[TYP_UNSIGNED_BIT];
        case (mt_size_e'(typ_i[1:0]))
            MT_B:    data_o = {{56{sgn & shifted[7]}},  shifted[7:0]};
            MT_H:    data_o = {{48{sgn & shifted[15]}}, shifted[15:0]};
            MT_W:    data_o = {{32{sgn & shifted[31]}}, shifted[31:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/hella_cache_mem_responder.sv
// Three-stage HellaCache dmem responder (s0 accept, s1 data/kill, s2 resp/nack)
// backed by a local word-addressed 64-bit memory.
module hella_cache_mem_responder
    import hella_cache_pkg::*;
#(
    parameter int unsigned NUM_ADDR_BITS = 40,
    parameter int unsigned NUM_DATA_BITS = 64,
    parameter int unsigned NUM_TAG_BITS  = 7,
    parameter int unsigned DEPTH_WORDS   = 1024
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     stall,
    output logic                     req_ready,
    input  logic                     req_valid,
    input  logic [NUM_ADDR_BITS-1:0] req_addr,
    input  logic [NUM_TAG_BITS-1:0]  req_tag,
    input  logic [4:0]               req_cmd,
    input  logic [2:0]               req_typ,
    input  logic                     s1_kill,
    input  logic [NUM_DATA_BITS-1:0] s1_data,
    input  logic [7:0]               s1_data_mask,
    output logic                     s2_nack,
    output logic                     resp_valid,
    output logic [NUM_TAG_BITS-1:0]  resp_tag,
    output logic [2:0]               resp_typ,
    output logic [NUM_DATA_BITS-1:0] resp_data,
    output logic                     resp_has_data,
    output logic [NUM_DATA_BITS-1:0] resp_data_word_bypass
);

    localparam int unsigned IDX_BITS   = $clog2(DEPTH_WORDS);
    localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH_WORDS) * 64'd8;

    pipe_reg_t s1_q, s1_d, s2_q, s2_d;
    logic [63:0] s2_word_q, s2_word_d;
    logic [63:0] mem_q [DEPTH_WORDS];

    logic [IDX_BITS-1:0] s1_idx, s2_idx;
    logic [63:0] s1_old, bytemask, load_data;
    logic        s2_commit, resp_ok, s2_load;
    logic        unused_s2_bits;

    assign req_ready = ~stall;
    assign s1_idx    = s1_q.addr[IDX_BITS+2:3];
    assign s2_idx    = s2_q.addr[IDX_BITS+2:3];
    assign s2_commit = s2_q.valid & ~s2_q.err & (s2_q.cmd == M_XWR);
    assign unused_s2_bits = ^{s2_q.addr, s2_q.tag};

    // s0: capture an accepted request; unsupported commands flagged early
    always_comb begin
        s1_d       = '0;
        s1_d.valid = req_valid & req_ready;
        s1_d.addr  = 64'(req_addr);
        s1_d.tag   = 16'(req_tag);
        s1_d.cmd   = req_cmd;
        s1_d.typ   = req_typ;
        s1_d.err   = ~((req_cmd == M_XRD) | (req_cmd == M_XWR));
    end

    // s1: read (forwarding a committing store), merge store data, finish error check
    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            bytemask[i*8 +: 8] = {8{s1_data_mask[i]}};
        end
        s1_old    = (s2_commit && (s2_idx == s1_idx)) ? s2_word_q : mem_q[s1_idx];
        s2_d       = s1_q;
        s2_d.valid = s1_q.valid & ~s1_kill;
        s2_d.err   = s1_q.err | (s1_q.addr >= ADDR_LIMIT)
                   | misaligned(s1_q.addr[2:0], s1_q.typ[1:0]);
        s2_word_d  = (s1_q.cmd == M_XWR) ? ((s1_old & ~bytemask) | (s1_data & bytemask))
                                         : s1_old;
    end

    // Pipeline valid/control registers; reset drops any in-flight op
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Data word register and memory write; contents are not reset
    always_ff @(posedge clock) begin
        s2_word_q <= s2_word_d;
        if (s2_commit) begin
            mem_q[s2_idx] <= s2_word_q;
        end
    end

    hella_load_extract u_extract (
        .word_i (s2_word_q),
        .off_i  (s2_q.addr[2:0]),
        .typ_i  (s2_q.typ),
        .data_o (load_data)
    );

    // s2 outputs: one-cycle pulses, zero when no response is presented
    always_comb begin
        resp_ok               = s2_q.valid & ~s2_q.err;
        s2_load               = resp_ok & (s2_q.cmd == M_XRD);
        s2_nack               = s2_q.valid & s2_q.err;
        resp_valid            = resp_ok;
        resp_tag              = resp_ok ? s2_q.tag[NUM_TAG_BITS-1:0] : '0;
        resp_typ              = resp_ok ? s2_q.typ : '0;
        resp_has_data         = s2_load;
        resp_data             = s2_load ? load_data : '0;
        resp_data_word_bypass = s2_load ? s2_word_q : '0;
    end

endmodule

// File: tb/tb_hella_cache_mem_responder.sv
// Directed + random bench for hella_cache_mem_responder with a byte-level
// reference model that processes ops in program order.
module tb_hella_cache_mem_responder;

    localparam int unsigned AW    = 40;
    localparam int unsigned DW    = 64;
    localparam int unsigned TW    = 7;
    localparam int unsigned DEPTH = 64;

    logic          clock = 1'b0;
    logic          reset_n, stall, req_ready, req_valid;
    logic [AW-1:0] req_addr;
    logic [TW-1:0] req_tag;
    logic [4:0]    req_cmd;
    logic [2:0]    req_typ;
    logic          s1_kill;
    logic [DW-1:0] s1_data;
    logic [7:0]    s1_data_mask;
    logic          s2_nack, resp_valid, resp_has_data;
    logic [TW-1:0] resp_tag;
    logic [2:0]    resp_typ;
    logic [DW-1:0] resp_data, resp_data_word_bypass;

    always #5 clock = ~clock;

    hella_cache_mem_responder #(
        .NUM_ADDR_BITS (AW),
        .NUM_DATA_BITS (DW),
        .NUM_TAG_BITS  (TW),
        .DEPTH_WORDS   (DEPTH)
    ) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .stall                 (stall),
        .req_ready             (req_ready),
        .req_valid             (req_valid),
        .req_addr              (req_addr),
        .req_tag               (req_tag),
        .req_cmd               (req_cmd),
        .req_typ               (req_typ),
        .s1_kill               (s1_kill),
        .s1_data               (s1_data),
        .s1_data_mask          (s1_data_mask),
        .s2_nack               (s2_nack),
        .resp_valid            (resp_valid),
        .resp_tag              (resp_tag),
        .resp_typ              (resp_typ),
        .resp_data             (resp_data),
        .resp_has_data         (resp_has_data),
        .resp_data_word_bypass (resp_data_word_bypass)
    );

    typedef struct packed {
        logic          v;
        logic [AW-1:0] addr;
        logic [TW-1:0] tag;
        logic [4:0]    cmd;
        logic [2:0]    typ;
        logic          kill;
        logic [63:0]   data;
        logic [7:0]    mask;
    } op_t;

    typedef struct packed {
        logic          resp;
        logic          nack;
        logic [TW-1:0] tag;
        logic [2:0]    typ;
        logic          has;
        logic [63:0]   data;
        logic [63:0]   word;
    } exp_t;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    logic [63:0] mm [DEPTH];
    logic [TW-1:0] next_tag = '0;
    op_t  s1_op = '0;
    exp_t exp_s2 = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic op_t mk(input logic [4:0] cmd, input logic [63:0] addr, input logic [2:0] typ,
                               input logic [63:0] data, input logic [7:0] mask, input logic kill);
        op_t o;
        o.v = 1'b1; o.addr = AW'(addr); o.tag = next_tag; o.cmd = cmd; o.typ = typ;
        o.data = data; o.mask = mask; o.kill = kill;
        next_tag = next_tag + 1'b1;
        return o;
    endfunction

    // Reference: error rules, byte-masked store, arithmetic extract/extend
    function automatic exp_t model(input op_t o);
        exp_t e;
        logic [63:0] a, w, val, lim, size;
        e = '0;
        a = 64'(o.addr);
        size = 64'd1 << o.typ[1:0];
        if (!o.v || o.kill) return e;
        if (o.cmd > 5'd1 || a >= 64'(DEPTH) * 8 || (a % size) != 0) begin
            e.nack = 1'b1;
            return e;
        end
        e.resp = 1'b1; e.tag = o.tag; e.typ = o.typ;
        w = a / 8;
        if (o.cmd == 5'd1) begin
            for (int i = 0; i < 8; i++)
                if (o.mask[i]) mm[int'(w)][8*i +: 8] = o.data[8*i +: 8];
            return e;
        end
        val = mm[int'(w)] >> (8 * (a % 8));
        if (size < 8) begin
            lim = 64'd1 << (8 * size);
            val = val % lim;
            if (!o.typ[2] && val >= lim / 2) val = val - lim;
        end
        e.has = 1'b1; e.data = val; e.word = mm[int'(w)];
        return e;
    endfunction

    // One cycle: check s2 outputs, drive s0 request and s1 data, advance model
    task automatic step(input op_t o, input logic stl);
        exp_t nx;
        chk("resp_valid", 64'(resp_valid), 64'(exp_s2.resp));
        chk("s2_nack", 64'(s2_nack), 64'(exp_s2.nack));
        if (exp_s2.resp) begin
            chk("resp_tag", 64'(resp_tag), 64'(exp_s2.tag));
            chk("resp_typ", 64'(resp_typ), 64'(exp_s2.typ));
            chk("resp_has_data", 64'(resp_has_data), 64'(exp_s2.has));
            chk("resp_data", resp_data, exp_s2.data);
            if (exp_s2.has) chk("resp_word", resp_data_word_bypass, exp_s2.word);
        end else begin
            chk("idle_resp_data", resp_data, 64'd0);
        end
        stall = stl;
        req_valid = o.v; req_addr = o.addr; req_tag = o.tag; req_cmd = o.cmd; req_typ = o.typ;
        s1_kill = s1_op.v & s1_op.kill; s1_data = s1_op.data; s1_data_mask = s1_op.mask;
        nx = model(s1_op);
        #1;
        chk("req_ready", 64'(req_ready), 64'(!stl));
        @(posedge clock);
        exp_s2 = reset_n ? nx : '0;
        s1_op  = (o.v && !stl && reset_n) ? o : '0;
        @(negedge clock);
    endtask

    function automatic op_t rand_op();
        op_t o;
        int unsigned r;
        logic [2:0]  typ;
        logic [63:0] addr, size;
        logic [4:0]  cmd;
        r = $urandom_range(0, 99);
        typ = 3'($urandom_range(0, 7));
        size = 64'd1 << typ[1:0];
        addr = 64'($urandom_range(0, 127));
        if (r % 4 != 0) addr = addr & ~(size - 1);
        if (r < 5) addr = 64'(DEPTH) * 8 + 64'($urandom_range(0, 64));
        cmd = (r < 40) ? 5'd1 : 5'd0;
        if (r >= 40 && r < 45) cmd = 5'($urandom_range(2, 31));
        o = mk(cmd, addr, typ, {$urandom, $urandom}, 8'($urandom), r % 10 == 7);
        if ($urandom_range(0, 9) == 0) o.v = 1'b0;
        return o;
    endfunction

    initial begin
        reset_n = 1'b0; stall = 1'b0; req_valid = 1'b0; req_addr = '0; req_tag = '0;
        req_cmd = '0; req_typ = '0; s1_kill = 1'b0; s1_data = '0; s1_data_mask = '0;
        repeat (3) @(negedge clock);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_s2_nack", 64'(s2_nack), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        reset_n = 1'b1;

        for (int w = 0; w < 16; w++) step(mk(5'd1, 64'(w * 8), 3'd3, {$urandom, $urandom}, 8'hFF, 1'b0), 1'b0);

        // Directed load/store, extension and forwarding
        step(mk(5'd1, 64'h40, 3'd3, 64'h1122334455667788, 8'hFF, 1'b0), 1'b0);
        step(mk(5'd0, 64'h40, 3'd3, '0, '0, 1'b0), 1'b0);
        step(mk(5'd0, 64'h47, 3'd0, '0, '0, 1'b0), 1'b0);
        step(mk(5'd1, 64'h41, 3'd0, 64'h8000, 8'h02, 1'b0), 1'b0);
        step(mk(5'd0, 64'h41, 3'd0, '0, '0, 1'b0), 1'b0);
        step(mk(5'd0, 64'h41, 3'd4, '0, '0, 1'b0), 1'b0);
        step(mk(5'd1, 64'h40, 3'd3, 64'hAAAAAAAABBBBBBBB, 8'h0F, 1'b0), 1'b0);
        step(mk(5'd0, 64'h40, 3'd3, '0, '0, 1'b0), 1'b0);
        // Error cases
        step(mk(5'd0, 64'(DEPTH) * 8, 3'd3, '0, '0, 1'b0), 1'b0);
        step(mk(5'd0, 64'h41, 3'd1, '0, '0, 1'b0), 1'b0);
        step(mk(5'd6, 64'h40, 3'd3, '0, '0, 1'b0), 1'b0);
        // Killed store leaves memory unchanged
        step(mk(5'd1, 64'h48, 3'd3, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1), 1'b0);
        step(mk(5'd0, 64'h48, 3'd3, '0, '0, 1'b0), 1'b0);
        // Stall for three cycles mid-stream
        for (int i = 0; i < 8; i++)
            step(mk(5'd0, 64'(i * 8), 3'd3, '0, '0, 1'b0), (i >= 2 && i <= 4));

        for (int i = 0; i < 300; i++) step(rand_op(), $urandom_range(0, 9) == 0);

        // Reset with loads in s1 and s2
        step(mk(5'd0, 64'h10, 3'd3, '0, '0, 1'b0), 1'b0);
        step(mk(5'd0, 64'h18, 3'd3, '0, '0, 1'b0), 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_s2_nack", 64'(s2_nack), 64'd0);
        chk("mid_rst_resp_data", resp_data, 64'd0);
        chk("mid_rst_resp_word", resp_data_word_bypass, 64'd0);
        chk("mid_rst_resp_tag", 64'(resp_tag), 64'd0);
        exp_s2 = '0;
        s1_op  = '0;
        step(mk(5'd0, 64'h20, 3'd3, '0, '0, 1'b0), 1'b0);
        step(mk(5'd0, 64'h28, 3'd3, '0, '0, 1'b0), 1'b0);
        reset_n = 1'b1;
        step(mk(5'd0, 64'h30, 3'd2, '0, '0, 1'b0), 1'b0);
        repeat (3) step('0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
